shift_unit_arbiter: RTL and testbench

- Shares one signed shifter datapath (left shift / arithmetic right shift) between NREQ requesters.
- Round-robin arbitration, valid/ready handshakes on each request port, one-deep registered result slot with valid/ready output handshake.
- Sits between the scheduled datapath's operation issuers and the single physical shift resource, so multiple shift operations per schedule step need only one shifter.

---
 rtl/shift_unit_arbiter.sv | 106 ++++++++++
 tb/tb_shift_unit_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - round-robin arbiter sharing one signed shifter with a one-deep result slot
module shift_unit_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATAWIDTH-1:0] req_a,
  input  logic [NREQ*DATAWIDTH-1:0] req_sh_amt,
  input  logic [NREQ-1:0]           req_dir,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATAWIDTH-1:0]      rsp_d,
  output logic [IDW-1:0]            rsp_id
);

  localparam int PADW = 1 << IDW;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_next;
  logic [IDW-1:0]       rr_ptr;
  logic [PADW-1:0]      valid_pad;
  logic [PADW-1:0]      ready_pad;
  logic [IDW:0]         cand;
  logic                 grant_any;
  logic [IDW-1:0]       grant_idx;
  logic                 free;
  logic                 transfer;
  logic [DATAWIDTH-1:0] sel_a;
  logic [DATAWIDTH-1:0] sel_amt;
  logic                 sel_dir;
  logic [DATAWIDTH-1:0] shift_res;

  assign valid_pad = PADW'(req_valid);
  assign rsp_valid = (state == FULL);
  assign free      = !rsp_valid || rsp_ready;
  assign transfer  = free && grant_any && !Rst;

  // First valid requester found walking up from rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_any && valid_pad[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ready_pad = '0;
    if (transfer) ready_pad[grant_idx] = 1'b1;
    req_ready = ready_pad[NREQ-1:0];
  end

  always_comb begin
    sel_a   = req_a[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
    sel_amt = req_sh_amt[int'(grant_idx)*DATAWIDTH +: DATAWIDTH];
    sel_dir = req_dir[grant_idx];
  end

  // Full-width shift amount: anything at or beyond DATAWIDTH saturates.
  always_comb begin
    shift_res = '0;
    if (!sel_dir) begin
      if (sel_amt < DATAWIDTH'(DATAWIDTH)) shift_res = sel_a << sel_amt;
    end else begin
      if (sel_amt < DATAWIDTH'(DATAWIDTH)) shift_res = $signed(sel_a) >>> sel_amt;
      else                                 shift_res = {DATAWIDTH{sel_a[DATAWIDTH-1]}};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (transfer) state_next = FULL;
      FULL:    if (!transfer && rsp_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= EMPTY;
      rsp_d  <= '0;
      rsp_id <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (transfer) begin
        rsp_d  <= shift_res;
        rsp_id <= grant_idx;
        rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - directed self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_sh_amt;
  logic [3:0]   req_dir;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_d;
  logic [1:0]   rsp_id;

  logic [31:0] a_v   [4];
  logic [31:0] amt_v [4];
  logic [31:0] rr_exp[4];
  logic [31:0] bv_a  [6];
  logic [31:0] bv_amt[6];
  logic        bv_dir[6];
  logic [31:0] bv_exp[6];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32]      = a_v[i];
      req_sh_amt[i*32 +: 32] = amt_v[i];
    end
  end

  shift_unit_arbiter #(.DATAWIDTH(32), .NREQ(4), .IDW(2)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_sh_amt (req_sh_amt),
    .req_dir    (req_dir),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_d      (rsp_d),
    .rsp_id     (rsp_id)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    int g;
    bv_a[0] = 32'h8000_0000; bv_amt[0] = 31;           bv_dir[0] = 1; bv_exp[0] = 32'hFFFF_FFFF;
    bv_a[1] = 32'h8000_0000; bv_amt[1] = 40;           bv_dir[1] = 1; bv_exp[1] = 32'hFFFF_FFFF;
    bv_a[2] = 32'h7FFF_FFFF; bv_amt[2] = 32;           bv_dir[2] = 0; bv_exp[2] = 32'h0000_0000;
    bv_a[3] = 32'h1234_5678; bv_amt[3] = 0;            bv_dir[3] = 1; bv_exp[3] = 32'h1234_5678;
    bv_a[4] = 32'h0000_0001; bv_amt[4] = 32'h8000_0001; bv_dir[4] = 0; bv_exp[4] = 32'h0000_0000;
    bv_a[5] = 32'h8000_0000; bv_amt[5] = 4;            bv_dir[5] = 1; bv_exp[5] = 32'hF800_0000;
    rr_exp[0] = 32'd1; rr_exp[1] = 32'd4; rr_exp[2] = 32'd12; rr_exp[3] = 32'd32;

    Rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1; req_dir = 4'b0000;
    for (int i = 0; i < 4; i++) begin a_v[i] = '0; amt_v[i] = '0; end
    #1;
    check("ready_during_reset", 64'(req_ready), 64'h0);
    step();
    step();
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_d", 64'(rsp_d), 64'h0);
    check("reset_rsp_id", 64'(rsp_id), 64'h0);

    // single request from requester 2
    Rst = 1'b0; req_valid = 4'b0100; a_v[2] = 32'h3; amt_v[2] = 4;
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    step();
    check("single_valid", 64'(rsp_valid), 64'h1);
    check("single_d", 64'(rsp_d), 64'h30);
    check("single_id", 64'(rsp_id), 64'h2);
    req_valid = 4'b0000;
    step();
    check("consume_valid", 64'(rsp_valid), 64'h0);
    check("consume_d_hold", 64'(rsp_d), 64'h30);

    // round robin, pointer currently 3 after the grant to requester 2
    for (int i = 0; i < 4; i++) begin a_v[i] = 32'(i + 1); amt_v[i] = 32'(i); end
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      g = (3 + c) % 4;
      #1;
      check($sformatf("rr_ready_%0d", c), 64'(req_ready), 64'(4'b0001 << g));
      step();
      check($sformatf("rr_valid_%0d", c), 64'(rsp_valid), 64'h1);
      check($sformatf("rr_id_%0d", c), 64'(rsp_id), 64'(g));
      check($sformatf("rr_d_%0d", c), 64'(rsp_d), 64'(rr_exp[g]));
    end

    // backpressure with slot holding requester 3's result
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp_ready_%0d", c), 64'(req_ready), 64'h0);
      step();
      check($sformatf("bp_valid_%0d", c), 64'(rsp_valid), 64'h1);
      check($sformatf("bp_id_%0d", c), 64'(rsp_id), 64'h3);
      check($sformatf("bp_d_%0d", c), 64'(rsp_d), 64'd32);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'h1);
    step();
    check("bp_release_id", 64'(rsp_id), 64'h0);
    check("bp_release_d", 64'(rsp_d), 64'h1);

    // shift boundaries through requester 1
    req_valid = 4'b0010;
    for (int v = 0; v < 6; v++) begin
      a_v[1] = bv_a[v]; amt_v[1] = bv_amt[v]; req_dir[1] = bv_dir[v];
      #1;
      check($sformatf("bnd_ready_%0d", v), 64'(req_ready), 64'h2);
      step();
      check($sformatf("bnd_d_%0d", v), 64'(rsp_d), 64'(bv_exp[v]));
      check($sformatf("bnd_id_%0d", v), 64'(rsp_id), 64'h1);
    end

    // reset while a result is pending and requester 3 is waiting
    rsp_ready = 1'b0; req_valid = 4'b1000; Rst = 1'b1;
    #1;
    check("midrst_ready", 64'(req_ready), 64'h0);
    step();
    check("midrst_valid", 64'(rsp_valid), 64'h0);
    check("midrst_d", 64'(rsp_d), 64'h0);
    check("midrst_id", 64'(rsp_id), 64'h0);
    Rst = 1'b0; rsp_ready = 1'b1; req_valid = 4'b1010;
    #1;
    check("postrst_ready", 64'(req_ready), 64'h2);
    step();
    check("postrst_id", 64'(rsp_id), 64'h1);
    #1;
    check("postrst_next_ready", 64'(req_ready), 64'h8);
    step();
    check("postrst_next_id", 64'(rsp_id), 64'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
